mem_bus_ctrl: RTL and testbench

//  Synchronous MAR/MDR controller between the CPU datapath and the asynchronous-handshake

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/sync_bit.sv | 20 ++
 rtl/mem_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MAR/MDR memory bus controller.
// The optional MFC timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer: a STAGES-deep flop chain with synchronous reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// MAR/MDR controller bridging the CPU to the MFC-handshake memory.
// Define MEM_TIMEOUT_EN to abort transfers whose MFC edge never arrives.
//
// state   | meaning
// IDLE    | waiting for cpu_req
// SETUP   | address/RW/data driven, mem_en low for one cycle
// STROBE  | mem_en high, waiting for an MFC rising edge
// CAPTURE | mem_en high, read data latched into MDR
// RELEASE | mem_en low, waiting for MFC to fall
// DONE    | one-cycle cpu_ack
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy,
  output logic              err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_mfc
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("mem_bus_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 2");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rdata_q;
  logic              rw_q;
  logic              mfc_s;
  logic              low_seen;
  logic              accept;
  logic              strobe_go;
  logic              release_go;
  logic              timeout;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_mfc (
    .clk   (clk),
    .reset (reset),
    .d     (mem_mfc),
    .q     (mfc_s)
  );

  // A stale-high MFC must be seen low before its rise counts.
  assign strobe_go  = mfc_s && low_seen;
  assign release_go = !mfc_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:   state_nxt = STROBE;
      STROBE: begin
        if (strobe_go)    state_nxt = CAPTURE;
        else if (timeout) state_nxt = DONE;
      end
      CAPTURE: state_nxt = RELEASE;
      RELEASE: begin
        if (release_go || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar      <= '0;
      mdr      <= '0;
      rdata_q  <= '0;
      rw_q     <= 1'b0;
      low_seen <= 1'b0;
    end else begin
      if (accept) begin
        mar  <= cpu_addr;
        rw_q <= cpu_rw;
        if (cpu_rw == RW_WRITE) mdr <= cpu_wdata;
      end
      if (state == CAPTURE && rw_q == RW_READ) begin
        mdr     <= mem_rdata;
        rdata_q <= mem_rdata;
      end
      if (state == SETUP)                 low_seen <= 1'b0;
      else if (state == STROBE && !mfc_s) low_seen <= 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             err_set;

  // Down-counter reloads on the cycle before each wait state is entered.
  assign timeout = (state == STROBE || state == RELEASE) && (cnt == '0);
  assign err_set = timeout && ((state == STROBE && !strobe_go) ||
                               (state == RELEASE && !release_go));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == SETUP || state == CAPTURE) cnt <= CNT_W'(TIMEOUT_CYC - 1);
      else if (cnt != '0)                     cnt <= cnt - 1'b1;
      if (accept)       err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign cpu_ack   = (state == DONE);
  assign cpu_rdata = rdata_q;
  assign mem_en    = (state == STROBE) || (state == CAPTURE);
  assign mem_rw    = rw_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small asynchronous MFC memory model.
module tb_mem_bus_ctrl;

  localparam int MFC_DLY = 23;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        busy;
  logic        err;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_mfc;
  logic        model_mfc = 1'b0;
  logic        mfc_block = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int en_rises = 0;
  int unstable = 0;
  logic [15:0] ref_wdata, ref_addr;
  logic [15:0] mem [0:255];

  assign mem_mfc = model_mfc & ~mfc_block;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .busy(busy), .err(err), .mem_en(mem_en),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
  );

  always #5 clk = ~clk;

  // Memory model: acts on the EN rise, raises MFC after a delay, drops it after EN falls.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hABCD;
    mem[0] = 16'h7002; mem[1] = 16'hF0FF; mem[2] = 16'h2222;
    mem[3] = 16'h5047; mem[5] = 16'h1111; mem[7] = 16'hC042;
    forever begin
      wait (mem_en === 1'b1);
      #MFC_DLY;
      if (mem_rw) mem_rdata = mem[mem_addr[7:0]];
      else        mem[mem_addr[7:0]] = mem_wdata;
      model_mfc = 1'b1;
      wait (mem_en === 1'b0);
      #MFC_DLY;
      model_mfc = 1'b0;
    end
  end

  always @(posedge mem_en) begin
    en_rises++;
    ref_wdata = mem_wdata;
    ref_addr  = mem_addr;
  end

  always @(negedge clk)
    if (mem_en === 1'b1 && (mem_wdata !== ref_wdata || mem_addr !== ref_addr)) unstable++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer from IDLE and waits (bounded) for its ack.
  task automatic xfer(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                      output logic [15:0] rd, output int lat, output bit got_ack,
                      output logic acc_busy, output logic acc_err);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata;
    tick();
    cpu_req = 1'b0;
    acc_busy = busy;
    acc_err = err;
    lat = 0;
    got_ack = 1'b0;
    while (!got_ack && lat < 300) begin
      tick();
      lat++;
      if (cpu_ack === 1'b1) got_ack = 1'b1;
    end
    rd = cpu_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", cpu_ack); else n_pass++;
    n_checks++; if (cpu_rdata !== 16'h0) $display("FAIL reset_rdata: got %h want 0000", cpu_rdata); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_rw !== 1'b0)
      $display("FAIL reset_mem_bus: got addr %h wdata %h rw %b want 0", mem_addr, mem_wdata, mem_rw); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    logic [15:0] rd; int lat; bit ok; logic ab, ae; int base;
    base = en_rises;
    xfer(1'b1, 16'h0000, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (ab !== 1'b1) $display("FAIL read0_busy: got %b want 1", ab); else n_pass++;
    n_checks++; if (!ok || rd !== 16'h7002) $display("FAIL read0_data: got %h ack %0d want 7002", rd, ok); else n_pass++;
    n_checks++; if (lat != 12) $display("FAIL read0_latency: got %0d want 12", lat); else n_pass++;
    n_checks++; if (en_rises - base != 1) $display("FAIL read0_en_count: got %0d want 1", en_rises - base); else n_pass++;
    tick();
    n_checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL read0_after_ack: got ack %b busy %b want 0 0", cpu_ack, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int lat; bit ok; logic ab, ae;
    xfer(1'b1, 16'h0007, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (!ok || rd !== 16'hC042) $display("FAIL read7_data: got %h want C042", rd); else n_pass++;
    tick();
    xfer(1'b1, 16'h0003, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (ab !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", ab); else n_pass++;
    n_checks++; if (!ok || rd !== 16'h5047) $display("FAIL read3_data: got %h want 5047", rd); else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    logic [15:0] rd; int lat; bit ok; logic ab, ae;
    unstable = 0;
    xfer(1'b0, 16'h0010, 16'hABCD, rd, lat, ok, ab, ae);
    n_checks++; if (!ok) $display("FAIL write10_ack: got 0 want 1"); else n_pass++;
    n_checks++; if (mem[16] !== 16'hABCD) $display("FAIL write10_cell: got %h want ABCD", mem[16]); else n_pass++;
    tick();
    xfer(1'b1, 16'h0020, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (!ok || rd !== 16'hABCD) $display("FAIL read20_data: got %h want ABCD", rd); else n_pass++;
    tick();
    xfer(1'b0, 16'h0011, 16'h1234, rd, lat, ok, ab, ae);
    n_checks++; if (rd !== 16'hABCD) $display("FAIL write_holds_rdata: got %h want ABCD", rd); else n_pass++;
    tick();
    xfer(1'b1, 16'h0011, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (!ok || rd !== 16'h1234) $display("FAIL read11_data: got %h want 1234", rd); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL bus_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
    tick();
  endtask

  task automatic test_ignore_strobe();
    int acks = 0; int base; int n = 0; logic [15:0] rd = 16'hxxxx;
    base = en_rises;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0003;
    tick();
    cpu_req = 1'b0;
    while (mem_en !== 1'b1 && n < 20) begin tick(); n++; end
    cpu_req = 1'b1; cpu_addr = 16'h0005;
    tick();
    cpu_req = 1'b0;
    n_checks++; if (mem_addr !== 16'h0003) $display("FAIL ignore_addr: got %h want 0003", mem_addr); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin acks++; rd = cpu_rdata; end
    end
    n_checks++; if (acks != 1) $display("FAIL ignore_ack_count: got %0d want 1", acks); else n_pass++;
    n_checks++; if (rd !== 16'h5047) $display("FAIL ignore_data: got %h want 5047", rd); else n_pass++;
    n_checks++; if (en_rises - base != 1) $display("FAIL ignore_en_count: got %0d want 1", en_rises - base); else n_pass++;
  endtask

  task automatic test_reset_strobe();
    logic [15:0] rd; int lat; bit ok; logic ab, ae; int n = 0;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0002;
    tick();
    cpu_req = 1'b0;
    while (mem_en !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (mem_en !== 1'b1) $display("FAIL rst_strobe_reach: got %b want 1", mem_en); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (mem_en !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0)
      $display("FAIL rst_strobe_outputs: got en %b busy %b ack %b want 0 0 0", mem_en, busy, cpu_ack); else n_pass++;
    reset = 1'b0;
    repeat (10) tick();
    xfer(1'b1, 16'h0001, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (!ok || rd !== 16'hF0FF) $display("FAIL read1_after_rst: got %h want F0FF", rd); else n_pass++;
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] rd; int lat; bit ok; logic ab, ae; int n = 0;
    mfc_block = 1'b1;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0000;
    tick();
    cpu_req = 1'b0;
    while (mem_en !== 1'b1 && n < 20) begin tick(); n++; end
    n = 0;
    while (cpu_ack !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (n != 8) $display("FAIL timeout_latency: got %0d want 8", n); else n_pass++;
    n_checks++; if (err !== 1'b1 || mem_en !== 1'b0)
      $display("FAIL timeout_err: got err %b en %b want 1 0", err, mem_en); else n_pass++;
    n_checks++; if (cpu_rdata !== 16'hF0FF) $display("FAIL timeout_rdata: got %h want F0FF", cpu_rdata); else n_pass++;
    repeat (10) tick();
    mfc_block = 1'b0;
    tick();
    xfer(1'b1, 16'h0007, 16'h0, rd, lat, ok, ab, ae);
    n_checks++; if (ae !== 1'b0) $display("FAIL timeout_err_clear: got %b want 0", ae); else n_pass++;
    n_checks++; if (!ok || rd !== 16'hC042) $display("FAIL read_after_timeout: got %h want C042", rd); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_write_read();
    test_ignore_strobe();
    test_reset_strobe();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
